// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage: next-PC selection, a circular
// return-address stack and sticky stack-error flags.
module pc_unit #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_VEC = '0,
  parameter logic [WIDTH-1:0]   EXC_VEC   = 32'h80,
  parameter logic [WIDTH-1:0]   STEP      = 4,
  parameter int                 RAS_DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_freeze,
  input  logic                         i_exc,
  input  logic                         i_branch,
  input  logic                         i_call,
  input  logic                         i_ret,
  input  logic [WIDTH-1:0]             i_target,
  input  logic                         i_err_clr,
  output logic [WIDTH-1:0]             o_pc_out,
  output logic [WIDTH-1:0]             o_pc_plus,
  output logic [$clog2(RAS_DEPTH):0]   o_ras_count,
  output logic                         o_ras_ovf,
  output logic                         o_ras_unf
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]    r_top;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_pc_plus;
  logic [WIDTH-1:0] w_next_pc;
  logic [PW-1:0]    w_top_m1;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_set_ovf;
  logic             w_set_unf;

  assign w_pc_plus = r_pc + STEP;
  assign w_top_m1  = r_top - PW'(1);
  assign w_full    = (r_count == CW'(RAS_DEPTH));
  assign w_empty   = (r_count == '0);

  // r_top points at the next free slot; once full, that slot holds the oldest entry.
  always_comb begin
    w_next_pc = w_pc_plus;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    if (i_exc) begin
      w_next_pc = EXC_VEC;
    end else if (i_freeze) begin
      w_next_pc = r_pc;
    end else if (i_call) begin
      w_next_pc = i_target;
      w_push    = 1'b1;
      w_set_ovf = w_full;
    end else if (i_branch) begin
      w_next_pc = i_target;
    end else if (i_ret) begin
      if (w_empty) begin
        w_set_unf = 1'b1;
      end else begin
        w_next_pc = r_ras[w_top_m1];
        w_pop     = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_pc    <= RESET_VEC;
      r_top   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_pc <= w_next_pc;
      if (w_push) begin
        r_ras[r_top] <= w_pc_plus;
        r_top        <= r_top + PW'(1);
        if (!w_full) r_count <= r_count + CW'(1);
      end else if (w_pop) begin
        r_top   <= w_top_m1;
        r_count <= r_count - CW'(1);
      end
      // A set condition in the same cycle as err_clr leaves the flag set.
      r_ovf <= w_set_ovf | (r_ovf & ~i_err_clr);
      r_unf <= w_set_unf | (r_unf & ~i_err_clr);
    end
  end

  assign o_pc_out    = r_pc;
  assign o_pc_plus   = w_pc_plus;
  assign o_ras_count = r_count;
  assign o_ras_ovf   = r_ovf;
  assign o_ras_unf   = r_unf;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with default parameters
// (RESET_VEC 0, EXC_VEC 0x80, STEP 4, RAS_DEPTH 4).
module tb_pc_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        exc;
  logic        branch;
  logic        call;
  logic        ret;
  logic [31:0] target;
  logic        errClr;
  logic [31:0] pcOut;
  logic [31:0] pcPlus;
  logic [2:0]  rasCount;
  logic        rasOvf;
  logic        rasUnf;

  int assertCount = 0;
  int failCount   = 0;

  pc_unit dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_freeze    (freeze),
    .i_exc       (exc),
    .i_branch    (branch),
    .i_call      (call),
    .i_ret       (ret),
    .i_target    (target),
    .i_err_clr   (errClr),
    .o_pc_out    (pcOut),
    .o_pc_plus   (pcPlus),
    .o_ras_count (rasCount),
    .o_ras_ovf   (rasOvf),
    .o_ras_unf   (rasUnf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge, far from the next edge.
  task automatic applyStimulus(input logic iRst, input logic iFreeze, input logic iExc,
                               input logic iBranch, input logic iCall, input logic iRet,
                               input logic [31:0] iTarget, input logic iErrClr);
    rst    = iRst;
    freeze = iFreeze;
    exc    = iExc;
    branch = iBranch;
    call   = iCall;
    ret    = iRet;
    target = iTarget;
    errClr = iErrClr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  task automatic checkState(input string tag, input logic [31:0] expPc,
                            input logic [31:0] expCount, input logic expOvf,
                            input logic expUnf);
    checkOutput({tag, ".pc"},    pcOut,            expPc);
    checkOutput({tag, ".count"}, {29'h0, rasCount}, expCount);
    checkOutput({tag, ".ovf"},   {31'h0, rasOvf},   {31'h0, expOvf});
    checkOutput({tag, ".unf"},   {31'h0, rasUnf},   {31'h0, expUnf});
  endtask

  initial begin
    // Reset and sequential fetch
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkState("reset", 32'h0, 0, 1'b0, 1'b0);
    checkOutput("reset.pcPlus", pcPlus, 32'h4);
    idle(); checkOutput("seq1", pcOut, 32'h4);
    idle(); checkOutput("seq2", pcOut, 32'h8);
    idle(); checkState("seq3", 32'hC, 0, 1'b0, 1'b0);
    idle(); checkOutput("seq4", pcOut, 32'h10);

    // Freeze blocks a branch; exc overrides freeze
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0);
      checkOutput("freeze", pcOut, 32'h10);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0);
    checkOutput("freezeExc", pcOut, 32'h80);

    // Call and return
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 1'b0);
    checkOutput("branch20", pcOut, 32'h20);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 1'b0);
    checkState("call200", 32'h200, 1, 1'b0, 1'b0);
    idle(); checkOutput("callRun1", pcOut, 32'h204);
    idle(); checkOutput("callRun2", pcOut, 32'h208);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    checkState("ret24", 32'h24, 0, 1'b0, 1'b0);

    // Nested calls overflow the 4-entry stack; A0=0x1000 is lost
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1000, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2000, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3000, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4000, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5000, 1'b0);
    checkState("call4", 32'h5000, 4, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h6000, 1'b0);
    checkState("call5", 32'h6000, 4, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    checkState("ret1", 32'h5004, 3, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    checkState("ret2", 32'h4004, 2, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    checkState("ret3", 32'h3004, 1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    checkState("ret4", 32'h2004, 0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    checkState("ret5", 32'h2008, 0, 1'b1, 1'b1);
    idle(); checkState("sticky", 32'h200C, 0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkState("errClr", 32'h2010, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
    checkState("setBeatsClr", 32'h2014, 0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkState("errClr2", 32'h2018, 0, 1'b0, 1'b0);

    // Back-to-back return, call+ret acting as call, and exc priority
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    checkState("b2bRet", 32'h201C, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h400, 1'b0);
    checkState("callRet", 32'h400, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h500, 1'b0);
    checkState("excPrio", 32'h80, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    checkState("retAfterExc", 32'h2020, 0, 1'b0, 1'b0);

    // Wrap-around of the sequential increment
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0);
    checkOutput("wrapPlus", pcPlus, 32'h0);
    idle(); checkOutput("wrapPc", pcOut, 32'h0);

    // Reset in the middle of a call sequence discards the stack
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h30, 1'b0);
    checkState("preRst", 32'h30, 3, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h700, 1'b0);
    checkState("midRst", 32'h0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    checkState("postRstRet", 32'h4, 0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the fetch stage. It generalises the plain freezable PC register by adding:
- internal next-PC selection (sequential, branch, call, return, exception);
- a circular return-address stack (RAS) of configurable depth;
- sticky stack-error flags.

It drives the instruction-memory address and feeds the fetch/decode pipeline register.

## Interface
Parameters:
- WIDTH, 32, PC and address width in bits
- RESET_VEC, 0, PC value loaded on reset
- EXC_VEC, 32'h80, exception handler address
- STEP, 4, sequential increment
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-low reset (sampled at rising edge of clk while 0)
- freeze  input  1  hold PC and RAS (stall)
- exc  input  1  redirect to EXC_VEC
- branch  input  1  redirect to target
- call  input  1  redirect to target and push return address
- ret  input  1  redirect to popped return address
- target  input  WIDTH  branch/call destination
- err_clr  input  1  clear sticky error flags
- pc_out  output  WIDTH  current PC (registered)
- pc_plus  output  WIDTH  pc_out + STEP (combinational)
- ras_count  output  clog2(RAS_DEPTH)+1  valid RAS entries
- ras_ovf  output  1  sticky: push while full
- ras_unf  output  1  sticky: pop while empty

## Operation
Next-PC priority, evaluated each cycle:
- **exc**: always wins, even when freeze=1. PC←EXC_VEC. RAS untouched.
- **freeze=1** (and exc=0): PC and RAS hold. call, ret and branch are ignored. err_clr still acts.
- **call**: PC←target. Push pc_plus. If ras_count==RAS_DEPTH, overwrite the oldest entry (circular), keep ras_count at RAS_DEPTH, and set ras_ovf.
- **branch** (call=0): PC←target. RAS untouched.
- **ret** (call=0, branch=0):
  - ras_count>0: PC←top entry, pop, ras_count−1.
  - ras_count==0: PC←pc_plus and set ras_unf.
- **otherwise**: PC←pc_plus.

Arithmetic and flags:
- All arithmetic wraps modulo 2^WIDTH; no carry out.
- RAS is a top-of-stack pointer over RAS_DEPTH registers. The pointer wraps modulo RAS_DEPTH.
- Flag update: if err_clr and a set condition occur in the same cycle, set wins.

Reset (rst=0 at a clock edge), overriding all other inputs including exc:
- pc_out=RESET_VEC
- ras_count=0
- ras_ovf=0, ras_unf=0
- RAS entry contents are don't-care.

## Timing
- pc_out, ras_count and the flags are registered. A redirect or increment at edge N appears after edge N.
- pc_plus follows pc_out combinationally, with zero latency.
- Exactly one PC update per unfrozen cycle.
- Returns are available back-to-back: a push at edge N can be popped by ret at edge N+1, returning the pushed value.
- A simultaneous call and ret acts as a call only.
- Reset mid-sequence discards RAS state at that edge. The first post-reset cycle behaves from an empty stack.

## Test plan
- **Reset/sequential**: hold rst=0 for 2 cycles, release, idle 3 cycles. Required: pc_out = 0, then 4, 8, 12; ras_count=0; flags 0.
- **Freeze vs exc**: freeze=1 at pc 0x10 for 3 cycles with branch=1, target=0x100. Required: pc stays 0x10. Then assert exc with freeze=1. Required: pc=0x80 next cycle.
- **Call/return**: at pc 0x20, call target 0x200; run 2 cycles; ret. Required:
  - pc sequence 0x200, 0x204, 0x208, then 0x24;
  - ras_count goes 1 then 0.
- **Nested overflow**: 5 calls with RAS_DEPTH=4, from pcs A0..A4, then 5 rets. Required:
  - first 4 rets return A4+4, A3+4, A2+4, A1+4 (A0's entry was lost);
  - 5th ret goes to pc_plus;
  - ras_ovf=1 and ras_unf=1 stay set until err_clr.
- **Priority/wrap**: exc+call+branch together. Required: pc=EXC_VEC and ras_count unchanged. Separately, with pc=0xFFFFFFFC and idle, required next pc=0x0.
- **Sync reset mid-op**: rst=0 with call=1 and ras_count=3. Required: pc=RESET_VEC, ras_count=0, no push. A following ret with rst=1 sets ras_unf.
